ace_ccu_arbiter: RTL and testbench

// Serialising arbiter sharing the single CCU request path among NoSlvPorts shareable ACE request streams.

---
 rtl/ace_ccu_arbiter_pkg.sv | 68 ++++++
 rtl/ace_ccu_rr_pick.sv | 32 +++
 rtl/ace_ccu_arbiter.sv | 150 +++++++++++++++
 tb/tb_ace_ccu_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ace_ccu_arbiter_pkg.sv
// Types shared by the CCU request-path arbiter: ACE channel payloads, bus structs and FSM enums.
package ace_ccu_arbiter_pkg;

  localparam int unsigned IdWidth   = 4;
  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned LenWidth  = 8;
  localparam int unsigned AtopWidth = 6;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [LenWidth-1:0]  len;
    logic [AtopWidth-1:0] atop;
  } aw_chan_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic                 last;
  } w_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [LenWidth-1:0]  len;
  } ar_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [1:0]         resp;
  } b_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [DataWidth-1:0] data;
    logic [1:0]           resp;
    logic                 last;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } ace_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } ace_resp_t;

  typedef enum logic [2:0] {IDLE, AR_FWD, R_FWD, AW_FWD, W_FWD, B_WAIT} ccu_arb_state_e;
  typedef enum logic {READ, WRITE} ccu_rw_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/ace_ccu_rr_pick.sv
// Combinational round-robin picker: first requester at or after rr_ptr wins.
module ace_ccu_rr_pick
  import ace_ccu_arbiter_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned IdxW = idx_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] rr_ptr,
  output logic [N-1:0]    onehot,
  output logic [IdxW-1:0] idx
);

  logic [IdxW-1:0] p;
  logic            found;

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    p      = '0;
    for (int unsigned k = 0; k < N; k++) begin
      p = IdxW'((32'(rr_ptr) + k) % N);
      if (!found && req[p]) begin
        found     = 1'b1;
        onehot[p] = 1'b1;
        idx       = p;
      end
    end
  end

endmodule

// File: rtl/ace_ccu_arbiter.sv
// Serialises the shareable ACE request streams onto the single CCU port, one transaction in flight,
// so IDs pass through untouched.
module ace_ccu_arbiter
  import ace_ccu_arbiter_pkg::*;
#(
  parameter int unsigned NoSlvPorts = 4,
  parameter bit          ATOPs      = 1'b1,
  parameter type         req_t      = ace_req_t,
  parameter type         resp_t     = ace_resp_t,
  localparam int unsigned IdxW      = idx_width(NoSlvPorts)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  req_t            slv_reqs_i  [NoSlvPorts],
  output resp_t           slv_resps_o [NoSlvPorts],
  output req_t            mst_req_o,
  input  resp_t           mst_resp_i,
  output logic            busy_o,
  output logic [IdxW-1:0] gnt_idx_o
);

  ccu_arb_state_e        state, state_next;
  ccu_rw_e               rw_pref;
  logic [IdxW-1:0]       rr_ptr, gnt_idx, win_idx;
  logic [NoSlvPorts-1:0] ar_vec, aw_vec, win_onehot;
  logic                  atop_r, r_done;
  logic                  win_ar, win_aw, pick_read, grant;
  logic                  ar_hs, aw_hs, w_last_hs, b_hs, r_route, r_last_hs;
  req_t                  g_req;

  always_comb begin
    ar_vec = '0;
    aw_vec = '0;
    for (int unsigned p = 0; p < NoSlvPorts; p++) begin
      ar_vec[p] = slv_reqs_i[p].ar_valid;
      aw_vec[p] = slv_reqs_i[p].aw_valid;
    end
  end

  ace_ccu_rr_pick #(.N(NoSlvPorts)) u_pick (
    .req    (ar_vec | aw_vec),
    .rr_ptr (rr_ptr),
    .onehot (win_onehot),
    .idx    (win_idx)
  );

  assign win_ar    = |(win_onehot & ar_vec);
  assign win_aw    = |(win_onehot & aw_vec);
  assign pick_read = win_ar && (!win_aw || rw_pref == READ);
  assign grant     = (state == IDLE) && (|win_onehot);

  assign g_req     = slv_reqs_i[gnt_idx];
  assign ar_hs     = (state == AR_FWD) && g_req.ar_valid && mst_resp_i.ar_ready;
  assign aw_hs     = (state == AW_FWD) && g_req.aw_valid && mst_resp_i.aw_ready;
  assign w_last_hs = (state == W_FWD) && g_req.w_valid && mst_resp_i.w_ready && g_req.w.last;
  assign b_hs      = (state == B_WAIT) && mst_resp_i.b_valid && g_req.b_ready;
  // Atomic R beats may overtake B, so R is also routed while waiting for B.
  assign r_route   = (state == R_FWD) || ((state == B_WAIT) && atop_r && !r_done);
  assign r_last_hs = r_route && mst_resp_i.r_valid && g_req.r_ready && mst_resp_i.r.last;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant) state_next = pick_read ? AR_FWD : AW_FWD;
      AR_FWD:  if (ar_hs) state_next = R_FWD;
      R_FWD:   if (r_last_hs) state_next = IDLE;
      AW_FWD:  if (aw_hs) state_next = W_FWD;
      W_FWD:   if (w_last_hs) state_next = B_WAIT;
      B_WAIT:  if (b_hs) state_next = (atop_r && !(r_done || r_last_hs)) ? R_FWD : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mst_req_o = '0;
    case (state)
      AR_FWD: begin
        mst_req_o.ar       = g_req.ar;
        mst_req_o.ar_valid = g_req.ar_valid;
      end
      AW_FWD: begin
        mst_req_o.aw       = g_req.aw;
        mst_req_o.aw_valid = g_req.aw_valid;
      end
      W_FWD: begin
        mst_req_o.w       = g_req.w;
        mst_req_o.w_valid = g_req.w_valid;
      end
      B_WAIT:  mst_req_o.b_ready = g_req.b_ready;
      default: ;
    endcase
    if (r_route) mst_req_o.r_ready = g_req.r_ready;
    for (int unsigned p = 0; p < NoSlvPorts; p++) begin
      slv_resps_o[p] = '0;
      if (IdxW'(p) == gnt_idx) begin
        slv_resps_o[p].ar_ready = (state == AR_FWD) && mst_resp_i.ar_ready;
        slv_resps_o[p].aw_ready = (state == AW_FWD) && mst_resp_i.aw_ready;
        slv_resps_o[p].w_ready  = (state == W_FWD) && mst_resp_i.w_ready;
        if (state == B_WAIT) begin
          slv_resps_o[p].b       = mst_resp_i.b;
          slv_resps_o[p].b_valid = mst_resp_i.b_valid;
        end
        if (r_route) begin
          slv_resps_o[p].r       = mst_resp_i.r;
          slv_resps_o[p].r_valid = mst_resp_i.r_valid;
        end
      end
    end
  end

  // Grant bookkeeping: pointer, direction preference and atomic completion tracking.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr  <= '0;
      gnt_idx <= '0;
      rw_pref <= READ;
      atop_r  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      if (grant) begin
        gnt_idx <= win_idx;
        rr_ptr  <= (win_idx == IdxW'(NoSlvPorts - 1)) ? '0 : win_idx + IdxW'(1);
        if (win_ar && win_aw) rw_pref <= (rw_pref == READ) ? WRITE : READ;
        atop_r  <= 1'b0;
        r_done  <= 1'b0;
      end
      if (aw_hs) atop_r <= ATOPs & g_req.aw.atop[5];
      if ((state == B_WAIT) && r_last_hs) r_done <= 1'b1;
    end
  end

  assign busy_o    = (state != IDLE);
  assign gnt_idx_o = gnt_idx;

  // Responses the arbiter cannot route are left unacknowledged; flag them in simulation.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!mst_resp_i.b_valid || state == B_WAIT)
        else $error("ace_ccu_arbiter: B response outside B_WAIT");
      assert (!mst_resp_i.r_valid || r_route)
        else $error("ace_ccu_arbiter: R response with no open read");
    end
  end

endmodule

// File: tb/tb_ace_ccu_arbiter.sv
// Directed bench for ace_ccu_arbiter with two ports; grants checked against a scoreboard queue.
module tb_ace_ccu_arbiter;
  import ace_ccu_arbiter_pkg::*;

  localparam int unsigned N = 2;

  typedef struct packed {
    logic [0:0]         port;
    logic               wr;
    logic [IdWidth-1:0] id;
  } grant_t;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  ace_req_t  reqs  [N];
  ace_resp_t resps [N];
  ace_req_t  mreq;
  ace_resp_t mresp;
  logic      busy;
  logic [0:0] gnt;

  int     checks = 0;
  int     errors = 0;
  int     lat;
  int     g;
  int     served [N];
  grant_t sb [$];

  ace_ccu_arbiter #(
    .NoSlvPorts (N),
    .ATOPs      (1'b1),
    .req_t      (ace_req_t),
    .resp_t     (ace_resp_t)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .slv_reqs_i  (reqs),
    .slv_resps_o (resps),
    .mst_req_o   (mreq),
    .mst_resp_i  (mresp),
    .busy_o      (busy),
    .gnt_idx_o   (gnt)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    for (int p = 0; p < N; p++) begin
      reqs[p]         = '0;
      reqs[p].b_ready = 1'b1;
      reqs[p].r_ready = 1'b1;
    end
    mresp          = '0;
    mresp.ar_ready = 1'b1;
    mresp.aw_ready = 1'b1;
    mresp.w_ready  = 1'b1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_mst"}, {mreq.aw_valid, mreq.w_valid, mreq.ar_valid, mreq.b_ready, mreq.r_ready}, 0);
    for (int p = 0; p < N; p++)
      chk({tag, "_slv"}, {resps[p].aw_ready, resps[p].w_ready, resps[p].ar_ready,
                          resps[p].b_valid, resps[p].r_valid}, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    cyc();
    cyc();
    chk("rst_busy", busy, 0);
    chk("rst_gnt", gnt, 0);
    chk_quiet("rst");
    rst = 1'b0;
  endtask

  task automatic expect_grant(input logic port, input logic wr, input logic [IdWidth-1:0] id);
    grant_t e;
    e.port = port;
    e.wr   = wr;
    e.id   = id;
    sb.push_back(e);
  endtask

  task automatic wait_grant(input string tag);
    grant_t e;
    bit     seen;
    seen = 1'b0;
    lat  = 0;
    for (int i = 1; i <= 8 && !seen; i++) begin
      cyc();
      #1;
      if (mreq.ar_valid || mreq.aw_valid) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    chk({tag, "_grant_seen"}, seen, 1);
    if (!seen || sb.size() == 0) return;
    e = sb.pop_front();
    chk({tag, "_gnt_idx"}, gnt, e.port);
    chk({tag, "_dir"}, mreq.aw_valid, e.wr);
    chk({tag, "_one_chan"}, mreq.aw_valid & mreq.ar_valid, 0);
    chk({tag, "_id"}, e.wr ? mreq.aw.id : mreq.ar.id, e.id);
  endtask

  task automatic drive_r(input int port, input logic [IdWidth-1:0] id, input int beats);
    for (int i = 0; i < beats; i++) begin
      mresp.r_valid = 1'b1;
      mresp.r.id    = id;
      mresp.r.data  = 32'hD0 + 32'(i);
      mresp.r.last  = (i == beats - 1);
      #1;
      chk("r_valid", resps[port].r_valid, 1);
      chk("r_data", resps[port].r.data, 32'hD0 + 32'(i));
      chk("r_id", resps[port].r.id, id);
      chk("r_other_port", resps[1-port].r_valid, 0);
      chk("r_ready", mreq.r_ready, 1);
      cyc();
    end
    mresp.r_valid = 1'b0;
    mresp.r.last  = 1'b0;
  endtask

  task automatic drive_b(input int port, input logic [IdWidth-1:0] id);
    mresp.b_valid = 1'b1;
    mresp.b.id    = id;
    #1;
    chk("b_valid", resps[port].b_valid, 1);
    chk("b_id", resps[port].b.id, id);
    chk("b_other_port", resps[1-port].b_valid, 0);
    chk("b_ready", mreq.b_ready, 1);
    cyc();
    mresp.b_valid = 1'b0;
  endtask

  initial begin
    clear_inputs();

    // single read burst on port 0
    do_reset();
    reqs[0].ar_valid = 1'b1;
    reqs[0].ar.id    = 4'd3;
    reqs[0].ar.len   = 8'd3;
    expect_grant(1'b0, 1'b0, 4'd3);
    #1;
    chk("t1_idle_no_fwd", mreq.ar_valid, 0);
    chk("t1_idle_busy", busy, 0);
    wait_grant("t1");
    chk("t1_latency", lat, 1);
    chk("t1_len", mreq.ar.len, 3);
    chk("t1_busy", busy, 1);
    cyc();
    reqs[0].ar_valid = 1'b0;
    drive_r(0, 4'd3, 4);
    #1;
    chk("t1_busy_after_last", busy, 0);

    // simultaneous requests right after reset: port 0 first
    do_reset();
    reqs[0].ar_valid = 1'b1;
    reqs[0].ar.id    = 4'd5;
    reqs[1].ar_valid = 1'b1;
    reqs[1].ar.id    = 4'd6;
    expect_grant(1'b0, 1'b0, 4'd5);
    expect_grant(1'b1, 1'b0, 4'd6);
    wait_grant("t2a");
    chk("t2_p1_stalled", resps[1].ar_ready, 0);
    cyc();
    reqs[0].ar_valid = 1'b0;
    drive_r(0, 4'd5, 1);
    wait_grant("t2b");
    cyc();
    reqs[1].ar_valid = 1'b0;
    drive_r(1, 4'd6, 1);

    // fairness under continuous load
    reqs[0].ar_valid = 1'b1;
    reqs[0].ar.id    = 4'd1;
    reqs[1].ar_valid = 1'b1;
    reqs[1].ar.id    = 4'd2;
    served[0] = 0;
    served[1] = 0;
    for (int k = 0; k < 8; k++) expect_grant(1'(k % 2), 1'b0, 4'((k % 2) + 1));
    for (int k = 0; k < 8; k++) begin
      wait_grant("t3");
      g = int'(gnt);
      if (g < N) served[g]++;
      cyc();
      drive_r(g, (g == 0) ? 4'd1 : 4'd2, 1);
    end
    reqs[0].ar_valid = 1'b0;
    reqs[1].ar_valid = 1'b0;
    chk("t3_served_p0", served[0], 4);
    chk("t3_served_p1", served[1], 4);

    // read/write preference toggling on one port
    do_reset();
    reqs[1].ar_valid = 1'b1;
    reqs[1].ar.id    = 4'd8;
    reqs[1].aw_valid = 1'b1;
    reqs[1].aw.id    = 4'd7;
    reqs[1].w_valid  = 1'b1;
    reqs[1].w.data   = 32'h77;
    reqs[1].w.last   = 1'b1;
    expect_grant(1'b1, 1'b0, 4'd8);
    expect_grant(1'b1, 1'b1, 4'd7);
    expect_grant(1'b1, 1'b0, 4'd9);
    #1;
    chk("t4_w_stall_idle", resps[1].w_ready, 0);
    wait_grant("t4a");
    chk("t4_aw_blocked", resps[1].aw_ready, 0);
    cyc();
    reqs[1].ar.id = 4'd9;
    #1;
    chk("t4_w_stall_r", resps[1].w_ready, 0);
    chk("t4_no_w_fwd", mreq.w_valid, 0);
    drive_r(1, 4'd8, 1);
    wait_grant("t4b");
    chk("t4_ar_blocked", resps[1].ar_ready, 0);
    cyc();
    reqs[1].aw_valid = 1'b0;
    #1;
    chk("t4_w_fwd", mreq.w_valid, 1);
    chk("t4_w_data", mreq.w.data, 32'h77);
    chk("t4_w_ready", resps[1].w_ready, 1);
    cyc();
    reqs[1].w_valid = 1'b0;
    drive_b(1, 4'd7);
    wait_grant("t4c");
    cyc();
    reqs[1].ar_valid = 1'b0;
    drive_r(1, 4'd9, 1);

    // W presented ahead of its AW
    do_reset();
    reqs[0].w_valid = 1'b1;
    reqs[0].w.data  = 32'h11;
    reqs[0].w.last  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5_w_stall", resps[0].w_ready, 0);
      chk("t5_no_w", mreq.w_valid, 0);
      chk("t5_not_busy", busy, 0);
      cyc();
    end
    reqs[0].aw_valid = 1'b1;
    reqs[0].aw.id    = 4'd4;
    reqs[0].aw.len   = 8'd1;
    expect_grant(1'b0, 1'b1, 4'd4);
    wait_grant("t5");
    chk("t5_w_stall_aw", resps[0].w_ready, 0);
    cyc();
    reqs[0].aw_valid = 1'b0;
    #1;
    chk("t5_w0_ready", resps[0].w_ready, 1);
    chk("t5_w0_data", mreq.w.data, 32'h11);
    cyc();
    reqs[0].w.data = 32'h22;
    reqs[0].w.last = 1'b1;
    #1;
    chk("t5_w1_data", mreq.w.data, 32'h22);
    chk("t5_w1_last", mreq.w.last, 1);
    cyc();
    reqs[0].w_valid = 1'b0;
    reqs[0].w.last  = 1'b0;
    drive_b(0, 4'd4);
    #1;
    chk("t5_idle", busy, 0);

    // atomic write: R beat overtakes B
    do_reset();
    reqs[1].aw_valid = 1'b1;
    reqs[1].aw.id    = 4'd5;
    reqs[1].aw.atop  = 6'b100000;
    reqs[1].w_valid  = 1'b1;
    reqs[1].w.data   = 32'h66;
    reqs[1].w.last   = 1'b1;
    expect_grant(1'b1, 1'b1, 4'd5);
    wait_grant("t6");
    cyc();
    reqs[1].aw_valid = 1'b0;
    cyc();
    reqs[1].w_valid = 1'b0;
    drive_r(1, 4'd5, 1);
    #1;
    chk("t6_busy_after_r", busy, 1);
    drive_b(1, 4'd5);
    #1;
    chk("t6_idle_after_b", busy, 0);

    // reset in the middle of a write burst
    do_reset();
    reqs[1].aw_valid = 1'b1;
    reqs[1].aw.id    = 4'd9;
    reqs[1].aw.len   = 8'd3;
    reqs[1].w_valid  = 1'b1;
    reqs[1].w.data   = 32'h55;
    expect_grant(1'b1, 1'b1, 4'd9);
    wait_grant("t7");
    cyc();
    reqs[1].aw_valid = 1'b0;
    #1;
    chk("t7_w_fwd", mreq.w_valid, 1);
    chk("t7_gnt", gnt, 1);
    cyc();
    rst = 1'b1;
    cyc();
    chk("t7_busy", busy, 0);
    chk("t7_gnt_reset", gnt, 0);
    chk_quiet("t7_rst");
    rst = 1'b0;
    clear_inputs();
    cyc();

    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
